// File: rtl/univ_reg_ss_sr.sv
// WIDTH-bit universal register: synchronous reset/set, clock enable, and
// hold/load/shift/rotate/count operations with a registered count-wrap pulse.
module univ_reg_ss_sr #(
  parameter int               WIDTH   = 8,              // must be >= 2
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             sr,
  input  logic             ss,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             wrap
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CNTUP = 3'b110,
    MODE_CNTDN = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  mode_e            w_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;

  assign w_mode = mode_e'(mode);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (en) begin
      unique case (w_mode)
        MODE_HOLD:  w_q_nxt = r_q;
        MODE_LOAD:  w_q_nxt = d;
        MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], sin_l};
        MODE_SHR:   w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
        MODE_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        MODE_CNTUP: begin
          w_q_nxt    = r_q + ONE;
          w_wrap_nxt = (r_q == ONES);
        end
        MODE_CNTDN: begin
          w_q_nxt    = r_q - ONE;
          w_wrap_nxt = (r_q == '0);
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (sr) begin
      r_q    <= RST_VAL;
      r_wrap <= 1'b0;
    end else if (ss) begin
      r_q    <= SET_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q      = r_q;
  assign qb     = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_univ_reg_ss_sr.sv
// Scoreboard bench for univ_reg_ss_sr: an 8-bit default instance and a 2-bit
// instance with non-default reset/set values, directed plan plus random traffic.
module tb_univ_reg_ss_sr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance, default parameters
  logic       sr8 = 1'b0, ss8 = 1'b0, en8 = 1'b0, sinl8 = 1'b0, sinr8 = 1'b0;
  logic [2:0] mode8 = '0;
  logic [7:0] d8 = '0, q8, qb8;
  logic       soutl8, soutr8, wrap8;

  univ_reg_ss_sr dut8 (
    .clk(clk), .sr(sr8), .ss(ss8), .en(en8), .mode(mode8), .d(d8),
    .sin_l(sinl8), .sin_r(sinr8), .q(q8), .qb(qb8),
    .sout_l(soutl8), .sout_r(soutr8), .wrap(wrap8)
  );

  // 2-bit instance, RST_VAL=10, SET_VAL=01
  logic       sr2 = 1'b0, ss2 = 1'b0, en2 = 1'b0, sinl2 = 1'b0, sinr2 = 1'b0;
  logic [2:0] mode2 = '0;
  logic [1:0] d2 = '0, q2, qb2;
  logic       soutl2, soutr2, wrap2;

  univ_reg_ss_sr #(.WIDTH(2), .RST_VAL(2'b10), .SET_VAL(2'b01)) dut2 (
    .clk(clk), .sr(sr2), .ss(ss2), .en(en2), .mode(mode2), .d(d2),
    .sin_l(sinl2), .sin_r(sinr2), .q(q2), .qb(qb2),
    .sout_l(soutl2), .sout_r(soutr2), .wrap(wrap2)
  );

  typedef struct {
    int          id;
    int unsigned q;
    logic        wrap;
  } exp_t;

  exp_t exp8[$];
  exp_t exp2[$];

  int n_pass  = 0;
  int n_total = 0;
  int step_id = 0;

  // Reference state of each instance as plain integers.
  int unsigned m8 = 0;
  int unsigned m2 = 0;

  task automatic check(input string name, input int id, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s step %0d: got %0h required %0h", name, id, act, req);
  endtask

  // Next state from the operation definitions, computed on integers modulo 2^w.
  task automatic model_op(input int w, input int unsigned v, input logic e, input logic [2:0] m,
                          input int unsigned dd, input logic sl, input logic sri,
                          output int unsigned nv, output logic nw);
    int unsigned mx;
    mx = (1 << w) - 1;
    nv = v;
    nw = 1'b0;
    if (e) begin
      case (m)
        3'd0: nv = v;
        3'd1: nv = dd & mx;
        3'd2: nv = ((v << 1) | int'(sl)) & mx;
        3'd3: nv = (v >> 1) | (int'(sri) << (w - 1));
        3'd4: nv = ((v << 1) | (v >> (w - 1))) & mx;
        3'd5: nv = (v >> 1) | ((v & 1) << (w - 1));
        3'd6: begin nw = (v == mx); nv = (v + 1) % (mx + 1); end
        default: begin nw = (v == 0); nv = (v == 0) ? mx : v - 1; end
      endcase
    end
  endtask

  // Apply one cycle of stimulus to one instance and push the expected result.
  task automatic drive(input int unit, input logic s_r, input logic s_s, input logic e,
                       input logic [2:0] m, input logic [7:0] dd, input logic sl, input logic sri);
    int unsigned nv;
    logic        nw;
    exp_t        x;
    @(negedge clk);
    step_id++;
    if (unit == 8) begin
      sr8 = s_r; ss8 = s_s; en8 = e; mode8 = m; d8 = dd; sinl8 = sl; sinr8 = sri;
      if (s_r)      begin nv = 32'h00; nw = 1'b0; end
      else if (s_s) begin nv = 32'hFF; nw = 1'b0; end
      else model_op(8, m8, e, m, dd, sl, sri, nv, nw);
      m8 = nv;
      x.id = step_id; x.q = nv; x.wrap = nw;
      exp8.push_back(x);
    end else begin
      sr2 = s_r; ss2 = s_s; en2 = e; mode2 = m; d2 = dd[1:0]; sinl2 = sl; sinr2 = sri;
      if (s_r)      begin nv = 2; nw = 1'b0; end
      else if (s_s) begin nv = 1; nw = 1'b0; end
      else model_op(2, m2, e, m, dd, sl, sri, nv, nw);
      m2 = nv;
      x.id = step_id; x.q = nv; x.wrap = nw;
      exp2.push_back(x);
    end
  endtask

  task automatic op8(input logic [2:0] m, input logic [7:0] dd, input logic sl, input logic sri);
    drive(8, 1'b0, 1'b0, 1'b1, m, dd, sl, sri);
  endtask

  task automatic op2(input logic [2:0] m, input logic [7:0] dd);
    drive(2, 1'b0, 1'b0, 1'b1, m, dd, 1'b0, 1'b0);
  endtask

  // Monitors: one expected entry per clock edge while the queue is non-empty.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp8.size() > 0) begin
      e = exp8.pop_front();
      check("q8",      e.id, q8,            e.q);
      check("qb8",     e.id, qb8,           (~e.q) & 8'hFF);
      check("sout_l8", e.id, soutl8,        (e.q >> 7) & 1);
      check("sout_r8", e.id, soutr8,        e.q & 1);
      check("wrap8",   e.id, wrap8,         e.wrap);
    end
    if (exp2.size() > 0) begin
      e = exp2.pop_front();
      check("q2",      e.id, q2,            e.q);
      check("qb2",     e.id, qb2,           (~e.q) & 2'b11);
      check("sout_l2", e.id, soutl2,        (e.q >> 1) & 1);
      check("sout_r2", e.id, soutr2,        e.q & 1);
      check("wrap2",   e.id, wrap2,         e.wrap);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] pick_d();
    case ($urandom_range(0, 5))
      0: return 8'hFF;
      1: return 8'h00;
      2: return 8'h01;
      3: return 8'hFE;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    // 1: reset then load
    drive(8, 1'b1, 1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
    op8(3'b001, 8'hA5, 1'b0, 1'b0);
    // 2: shift / rotate
    op8(3'b001, 8'h81, 1'b0, 1'b0);
    op8(3'b010, 8'h00, 1'b0, 1'b0);
    op8(3'b100, 8'h00, 1'b0, 1'b0);
    op8(3'b001, 8'h81, 1'b0, 1'b0);
    op8(3'b101, 8'h00, 1'b0, 1'b0);
    op8(3'b001, 8'h81, 1'b0, 1'b0);
    op8(3'b011, 8'h00, 1'b0, 1'b1);
    // 3: count wrap both directions
    op8(3'b001, 8'hFE, 1'b0, 1'b0);
    repeat (3) op8(3'b110, 8'h00, 1'b0, 1'b0);
    op8(3'b001, 8'h01, 1'b0, 1'b0);
    repeat (2) op8(3'b111, 8'h00, 1'b0, 1'b0);
    // 4: priority sr > ss > en
    drive(8, 1'b1, 1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
    drive(8, 1'b0, 1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
    repeat (4) drive(8, 1'b0, 1'b0, 1'b0, 3'b110, 8'h3C, 1'b0, 1'b0);
    // 5: set on the wrap edge, reset mid-count
    op8(3'b001, 8'hFF, 1'b0, 1'b0);
    drive(8, 1'b0, 1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    op8(3'b001, 8'h37, 1'b0, 1'b0);
    op8(3'b110, 8'h00, 1'b0, 1'b0);
    drive(8, 1'b1, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    // random traffic on the 8-bit instance
    for (int i = 0; i < 300; i++)
      drive(8, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) != 0), 3'($urandom), pick_d(),
            1'($urandom), 1'($urandom));

    // 6: 2-bit instance with non-default reset/set values
    drive(2, 1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    op2(3'b001, 8'h03);
    op2(3'b110, 8'h00);
    op2(3'b110, 8'h00);
    op2(3'b001, 8'h02);
    op2(3'b100, 8'h00);
    op2(3'b111, 8'h00);
    op2(3'b111, 8'h00);
    for (int i = 0; i < 300; i++)
      drive(2, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) != 0), 3'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));

    // Let the monitors drain the last entries, bounded by a cycle budget.
    for (int i = 0; i < 10 && (exp8.size() + exp2.size()) > 0; i++) @(posedge clk);
    #2;
    n_total++;
    if ((exp8.size() + exp2.size()) == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, required 0", exp8.size() + exp2.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
